// File: rtl/univ_sync_fifo_pkg.sv
// Shared constants and helpers for the univ_sync_fifo block.
package univ_sync_fifo_pkg;

    // Pointer index width for a given depth; depth is a power of two >= 2.
    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/univ_sync_fifo_ram.sv
// Simple dual-port storage: synchronous write port, registered read port.
module univ_sync_fifo_ram #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read register holds its value until the next accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/univ_sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers, combinational flags, registered read data.
module univ_sync_fifo
    import univ_sync_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);

    localparam int ADDR_W = addr_w(FIFO_DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] wr_ptr_r;
    logic [ADDR_W:0] rd_ptr_r;
    logic            empty_s;
    logic            full_s;
    logic            wr_ok_s;
    logic            rd_ok_s;

    // Flags from pointers; the reset edge suppresses both accesses.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                  (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
        wr_ok_s = cs & wr_en & ~full_s & ~rst_n;
        rd_ok_s = cs & rd_en & ~empty_s & ~rst_n;
    end

    assign empty = empty_s;
    assign full  = full_s;

    // Pointer update; rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_r <= {(ADDR_W+1){1'b0}};
            rd_ptr_r <= {(ADDR_W+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    univ_sync_fifo_ram #(
        .DEPTH      (FIFO_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst_n),
        .we    (wr_ok_s),
        .waddr (wr_ptr_r[ADDR_W-1:0]),
        .wdata (data_in),
        .re    (rd_ok_s),
        .raddr (rd_ptr_r[ADDR_W-1:0]),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_univ_sync_fifo.sv
// Directed self-checking bench for univ_sync_fifo (depth 8, width 32).
module tb_univ_sync_fifo;

    logic        clk;
    logic        rst_n;
    logic        cs;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        empty;
    logic        full;

    int n_checks = 0;
    int n_fail   = 0;

    univ_sync_fifo #(.FIFO_DEPTH(8), .DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock with the given controls; outputs sampled 1 unit after the edge.
    task automatic step(input logic c, input logic w, input logic r, input logic [31:0] d);
        cs      = c;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
        cs    = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] d);
        step(1'b1, 1'b1, 1'b0, d);
    endtask

    task automatic rd();
        step(1'b1, 1'b0, 1'b1, 32'd0);
    endtask

    initial begin
        rst_n   = 1'b1;
        cs      = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 32'd0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b0;
        chk1("rst_empty", empty, 1'b1);
        chk1("rst_full", full, 1'b0);
        chk("rst_dout", data_out, 32'd0);

        // Basic order
        wr(32'd1);
        chk1("basic_empty_fall", empty, 1'b0);
        wr(32'd10);
        wr(32'd100);
        rd(); chk("basic_rd0", data_out, 32'd1);
        rd(); chk("basic_rd1", data_out, 32'd10);
        rd(); chk("basic_rd2", data_out, 32'd100);
        chk1("basic_empty_after3", empty, 1'b1);
        rd(); chk("basic_rd_empty_hold", data_out, 32'd100);
        chk1("basic_empty_end", empty, 1'b1);

        // Interleaved write/read
        for (int i = 0; i < 8; i++) begin
            wr(32'd1 << i);
            chk1("inter_empty0", empty, 1'b0);
            chk1("inter_full0", full, 1'b0);
            rd();
            chk("inter_rd", data_out, 32'd1 << i);
            chk1("inter_empty1", empty, 1'b1);
        end

        // Overflow
        for (int i = 0; i < 8; i++) begin
            chk1("ovf_full_before", full, 1'b0);
            wr(32'd1 << i);
        end
        chk1("ovf_full_after8", full, 1'b1);
        wr(32'd256);
        chk1("ovf_full_after9", full, 1'b1);
        for (int i = 0; i < 8; i++) begin
            rd();
            chk("ovf_rd", data_out, 32'd1 << i);
            chk1("ovf_full_fall", full, 1'b0);
        end
        chk1("ovf_empty_end", empty, 1'b1);

        // Wrap-around: single-entry traffic, then a full fill/drain
        for (int i = 0; i < 6; i++) begin
            wr(32'd5 + 32'(i));
            rd();
            chk("wrap_single", data_out, 32'd5 + 32'(i));
        end
        for (int i = 0; i < 8; i++) wr(32'hA0 + 32'(i));
        chk1("wrap_full", full, 1'b1);
        for (int i = 0; i < 8; i++) begin
            rd();
            chk("wrap_drain", data_out, 32'hA0 + 32'(i));
        end
        chk1("wrap_empty", empty, 1'b1);

        // Simultaneous access when full: read wins, write dropped
        for (int i = 0; i < 8; i++) wr(32'h100 + 32'(i));
        step(1'b1, 1'b1, 1'b1, 32'hDEAD);
        chk("simfull_dout", data_out, 32'h100);
        chk1("simfull_full", full, 1'b0);
        for (int i = 1; i < 8; i++) begin
            rd();
            chk("simfull_drain", data_out, 32'h100 + 32'(i));
        end
        chk1("simfull_empty", empty, 1'b1);

        // Simultaneous access, partly filled: both occur
        wr(32'h55);
        step(1'b1, 1'b1, 1'b1, 32'h66);
        chk("simmid_dout", data_out, 32'h55);
        chk1("simmid_empty", empty, 1'b0);
        rd();
        chk("simmid_rd", data_out, 32'h66);
        chk1("simmid_empty_end", empty, 1'b1);

        // Simultaneous access when empty: only the write occurs
        step(1'b1, 1'b1, 1'b1, 32'h77);
        chk("simempty_hold", data_out, 32'h66);
        chk1("simempty_empty", empty, 1'b0);
        rd();
        chk("simempty_rd", data_out, 32'h77);

        // Chip select gating
        wr(32'h11);
        wr(32'h22);
        wr(32'h33);
        rd();
        chk("cs_rd", data_out, 32'h11);
        step(1'b0, 1'b1, 1'b0, 32'h99);
        chk1("cs_wr_empty", empty, 1'b0);
        chk1("cs_wr_full", full, 1'b0);
        chk("cs_wr_dout", data_out, 32'h11);
        step(1'b0, 1'b0, 1'b1, 32'd0);
        chk("cs_rd_dout", data_out, 32'h11);
        rd();
        chk("cs_next_rd", data_out, 32'h22);
        wr(32'h44);
        wr(32'h45);

        // Reset mid-operation with 3 entries, overriding a read and a write
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b1, 32'hBAD);
        rst_n = 1'b0;
        chk1("midrst_empty", empty, 1'b1);
        chk1("midrst_full", full, 1'b0);
        chk("midrst_dout", data_out, 32'd0);
        rd();
        chk("midrst_rd_empty", data_out, 32'd0);
        wr(32'hAB);
        rd();
        chk("midrst_fresh", data_out, 32'hAB);
        chk1("midrst_empty_end", empty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
